store_buffer: RTL and testbench

- Sits directly downstream of the store byte-lane shifter in the MEM stage.
- Accepts the already lane-aligned store word plus address and store type, derives the 4-bit byte enables, and queues the store in a small FIFO.
- Drains the FIFO to the data-memory write port over a req/ack handshake, so slow memory acks do not stall the pipeline until the buffer is full.

---
 rtl/store_buffer.sv | 114 +++++++++++
 tb/tb_store_buffer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: derives byte enables for lane-aligned stores and queues them for the data-memory write port.
// Optional load-hazard detection is enabled by defining STORE_BUF_LD_CHECK_EN.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_addr,
    input  logic [2:0]       in_store_sel,
    input  logic [31:0]      in_data,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    input  logic [31:0]      ld_addr,
    output logic             ld_conflict
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // swl/swr enables are contiguous runs anchored at the top or bottom lane.
    function automatic logic [3:0] calc_be(input logic [2:0] sel, input logic [1:0] lo);
        logic [3:0] be;
        case (sel)
            3'd0:    be = 4'b0001 << lo;
            3'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
            3'd2:    be = 4'b1111;
            3'd3:    be = 4'b1111 >> lo;
            3'd4:    be = 4'b1111 << (2'd3 - lo);
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    logic [29:0]      addr_mem_r [DEPTH];
    logic [31:0]      data_mem_r [DEPTH];
    logic [3:0]       be_mem_r   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_s;
    logic             full_s;
    logic             enq_s;
    logic             deq_s;
    logic             conflict_s;
    logic             unused_s;

    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign enq_s   = in_valid && !full_s;
    assign deq_s   = !empty_s && mem_ack;

    // Pointer and occupancy state; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(enq_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(deq_s);
            count_r  <= count_r + CNT_W'(enq_s) - CNT_W'(deq_s);
        end
    end

    // Entry storage; contents need no reset because validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            addr_mem_r[wr_ptr_r] <= in_addr[31:2];
            data_mem_r[wr_ptr_r] <= in_data;
            be_mem_r[wr_ptr_r]   <= calc_be(in_store_sel, in_addr[1:0]);
        end
    end

`ifdef STORE_BUF_LD_CHECK_EN
    logic [PTR_W-1:0] scan_idx_s;

    // Compare the load word against every occupied slot, head included.
    always_comb begin
        conflict_s = 1'b0;
        scan_idx_s = rd_ptr_r;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx_s = rd_ptr_r + PTR_W'(i);
            if ((CNT_W'(i) < count_r) && (addr_mem_r[scan_idx_s] == ld_addr[31:2])) begin
                conflict_s = 1'b1;
            end else begin
                conflict_s = conflict_s;
            end
        end
    end
    assign unused_s = ^ld_addr[1:0];
`else
    assign conflict_s = 1'b0;
    assign unused_s   = ^ld_addr;
`endif

    assign in_ready    = !full_s;
    assign mem_req     = !empty_s;
    assign mem_addr    = {addr_mem_r[rd_ptr_r], 2'b00};
    assign mem_wdata   = data_mem_r[rd_ptr_r];
    assign mem_be      = be_mem_r[rd_ptr_r];
    assign count       = count_r;
    assign empty       = empty_s;
    assign full        = full_s;
    assign ld_conflict = conflict_s;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: reset, byte-enable encoding, fill/drain, concurrency, load check.
module tb_store_buffer;

`ifdef STORE_BUF_LD_CHECK_EN
    localparam logic LDC = 1'b1;
`else
    localparam logic LDC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [2:0]  in_store_sel;
    logic [31:0] in_data;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic [31:0] ld_addr;
    logic        ld_conflict;

    int n_cmp = 0;
    int n_err = 0;

    store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_store_sel(in_store_sel), .in_data(in_data),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .count(count), .empty(empty), .full(full),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one store for a single cycle; returns at the next negedge with it visible.
    task automatic push(input logic [31:0] a, input logic [2:0] sel, input logic [31:0] d);
        in_valid = 1'b1; in_addr = a; in_store_sel = sel; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic ack_one();
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
    endtask

    logic [2:0]  v_sel  [10] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 3'd7};
    logic [1:0]  v_lo   [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
    logic [3:0]  v_be   [10] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001,
                                 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1100, 4'b1111};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = 32'h0; in_store_sel = 3'd0;
        in_data = 32'h0; mem_ack = 1'b0; ld_addr = 32'h0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_ldc", {31'b0, ld_conflict}, 32'd0);

        // Single sb at 0x1003
        push(32'h0000_1003, 3'd0, 32'hAB00_0000);
        check("sb_req", {31'b0, mem_req}, 32'd1);
        check("sb_addr", mem_addr, 32'h0000_1000);
        check("sb_be", {28'b0, mem_be}, 32'h8);
        check("sb_data", mem_wdata, 32'hAB00_0000);
        ack_one();
        check("sb_empty", {31'b0, empty}, 32'd1);

        // Ack while empty must not underflow
        ack_one();
        check("idle_ack_count", {29'b0, count}, 32'd0);

        // Byte-enable sweep
        for (int i = 0; i < 10; i++) begin
            push({30'h0000_0800, v_lo[i]}, v_sel[i], 32'h1234_5678);
            check($sformatf("be_sweep%0d", i), {28'b0, mem_be}, {28'b0, v_be[i]});
            ack_one();
        end
        check("sweep_empty", {31'b0, empty}, 32'd1);

        // Fill with no acks
        for (int k = 0; k < 4; k++) push(32'h10 + 32'(4 * k), 3'd2, 32'hD000_0000 + 32'(k));
        check("fill_full", {31'b0, full}, 32'd1);
        check("fill_ready", {31'b0, in_ready}, 32'd0);
        check("fill_count", {29'b0, count}, 32'd4);
        push(32'h99, 3'd2, 32'hDEAD_BEEF);
        check("fill_reject_count", {29'b0, count}, 32'd4);
        check("fill_head", mem_addr, 32'h10);
        check("fill_head_data", mem_wdata, 32'hD000_0000);
        // Enq+ack while full: only the dequeue happens
        in_valid = 1'b1; in_addr = 32'h200; in_store_sel = 3'd2; in_data = 32'h0;
        mem_ack = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; mem_ack = 1'b0; #1;
        check("full_enqdeq_count", {29'b0, count}, 32'd3);
        for (int k = 1; k < 4; k++) begin
            check($sformatf("drain_addr%0d", k), mem_addr, 32'h10 + 32'(4 * k));
            check($sformatf("drain_data%0d", k), mem_wdata, 32'hD000_0000 + 32'(k));
            ack_one();
        end
        check("drain_empty", {31'b0, empty}, 32'd1);

        // Simultaneous enqueue and dequeue at count=2
        push(32'h100, 3'd2, 32'hA0);
        push(32'h104, 3'd2, 32'hA1);
        in_valid = 1'b1; in_addr = 32'h108; in_store_sel = 3'd2; in_data = 32'hA2;
        mem_ack = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; mem_ack = 1'b0; #1;
        check("sim_count", {29'b0, count}, 32'd2);
        check("sim_head", mem_addr, 32'h104);
        push(32'h10C, 3'd2, 32'hA3);
        check("pre_rst_count", {29'b0, count}, 32'd3);
        rst = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b0; #1;
        check("mid_rst_count", {29'b0, count}, 32'd0);
        check("mid_rst_req", {31'b0, mem_req}, 32'd0);

        // Load conflict detection
        push(32'h50, 3'd2, 32'hB0);
        push(32'h40, 3'd2, 32'hB1);
        ld_addr = 32'h42; #1;
        check("ldc_hit", {31'b0, ld_conflict}, {31'b0, LDC});
        ld_addr = 32'h44; #1;
        check("ldc_miss", {31'b0, ld_conflict}, 32'd0);
        ack_one();
        ld_addr = 32'h42; mem_ack = 1'b1; #1;
        check("ldc_head_acked", {31'b0, ld_conflict}, {31'b0, LDC});
        @(negedge clk);
        mem_ack = 1'b0; #1;
        check("ldc_after_ack", {31'b0, ld_conflict}, 32'd0);
        check("ldc_final_empty", {31'b0, empty}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
